// File: rtl/emb_ram_param.sv
`default_nettype none
// ============================================================================
//  Module   : emb_ram_param
//  Purpose  : Single-clock word RAM with per-byte write enables, registered
//             read port (latency 1, write-first on same-address collision)
//             and a registered out-of-range exception flag.
//             Optional macro EMB_RAM_PARAM_INIT_EN adds a post-reset sweep
//             that zeroes every word while busy is held high.
//  Revision : 1.0 - initial release
// ============================================================================
module emb_ram_param #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         r_addr,
  input  logic                read,
  output logic [DATA_W-1:0]   r_line,
  output logic                r_valid,
  input  logic [31:0]         w_addr,
  input  logic [DATA_W-1:0]   w_line,
  input  logic [DATA_W/8-1:0] w_be,
  input  logic                write,
  output logic                exc,
  output logic                busy
);

  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          NBYTES  = DATA_W / 8;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  // Range checks use the full 32-bit address so aliasing upper bits never
  // sneak into the array.
  logic             rd_in, wr_in;
  logic             rd_acc, wr_acc;
  logic [IDX_W-1:0] rd_idx, wr_idx;

  assign rd_in  = (r_addr < DEPTH_U);
  assign wr_in  = (w_addr < DEPTH_U);
  assign rd_idx = r_addr[IDX_W-1:0];
  assign wr_idx = w_addr[IDX_W-1:0];
  assign rd_acc = read  & ~busy;
  assign wr_acc = write & ~busy;

`ifdef EMB_RAM_PARAM_INIT_EN
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    INIT = 1'b1
  } state_t;

  state_t           state, state_nx;
  logic [IDX_W-1:0] cnt, cnt_nx;

  // State and sweep counter register; reset restarts the sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Sweep one word per cycle, leave INIT after the last index is written.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (state == INIT) begin
      if (cnt == IDX_W'(DEPTH - 1)) begin
        state_nx = IDLE;
      end else begin
        cnt_nx = cnt + IDX_W'(1);
      end
    end
  end

  assign busy = (state == INIT);
`else
  assign busy = 1'b0;
`endif

  // Byte-merged write word; also serves as the write-first read bypass.
  logic [DATA_W-1:0] merged;
  always_comb begin
    merged = mem[wr_idx];
    for (int b = 0; b < NBYTES; b++) begin
      if (w_be[b]) merged[8*b +: 8] = w_line[8*b +: 8];
    end
  end

  // Single memory write port, shared between the init sweep and user writes.
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_data;
  logic [NBYTES-1:0] mem_be;
  always_comb begin
    mem_we   = wr_acc & wr_in;
    mem_idx  = wr_idx;
    mem_data = w_line;
    mem_be   = w_be;
`ifdef EMB_RAM_PARAM_INIT_EN
    if (busy) begin
      mem_we   = 1'b1;
      mem_idx  = cnt;
      mem_data = '0;
      mem_be   = '1;
    end
`endif
  end

  // Memory array update; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_data[8*b +: 8];
      end
    end
  end

  // Read data source, with same-edge same-address write forwarded.
  logic [DATA_W-1:0] rd_data;
  always_comb begin
    rd_data = mem[rd_idx];
    if (wr_acc && wr_in && (wr_idx == rd_idx)) rd_data = merged;
  end

  // Registered read response and exception flag (write takes priority).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line  <= '0;
      r_valid <= 1'b0;
      exc     <= 1'b0;
    end else begin
      r_valid <= rd_acc;
      r_line  <= (rd_acc && rd_in) ? rd_data : '0;
      if (wr_acc)      exc <= ~wr_in;
      else if (rd_acc) exc <= ~rd_in;
    end
  end

endmodule
`default_nettype wire

// File: doc/emb_ram_param.md
EMB_RAM_PARAM -- requirements
Module: emb_ram_param

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 1024, number of addressable words; SHALL be at least 2.
REQ-003 Port clk, input, 1, single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1: reset is asynchronous and active-low.
REQ-005 Port r_addr, input, 32, word read address.
REQ-006 Port read, input, 1, read request strobe.
REQ-007 Port r_line, output, DATA_W, registered read data.
REQ-008 Port r_valid, output, 1, r_line holds a read response this cycle.
REQ-009 Port w_addr, input, 32, word write address.
REQ-010 Port w_line, input, DATA_W, write data.
REQ-011 Port w_be, input, DATA_W/8, byte enables; bit i qualifies w_line[8i+7:8i].
REQ-012 Port write, input, 1, write request strobe.
REQ-013 Port exc, output, 1, registered out-of-range flag.
REQ-014 Port busy, output, 1, block ignores requests while high.

Function
REQ-015 In-range test SHALL be the full 32-bit unsigned compare addr < DEPTH; internal index width SHALL be clog2(DEPTH).
REQ-016 Request sampled at edge N with busy low: read response SHALL appear after edge N (latency 1); r_valid high for exactly that cycle.
REQ-017 In-range read SHALL give r_line = mem[r_addr]; out-of-range read SHALL give r_line = 0 and r_valid = 1.
REQ-018 While r_valid is low, r_line SHALL be driven 0, never high-impedance.
REQ-019 In-range write SHALL update, at edge N, only the bytes whose w_be bit is 1; w_be = 0 SHALL leave memory unchanged.
REQ-020 Out-of-range write SHALL leave memory unchanged.
REQ-021 Read and write to the same in-range address at the same edge SHALL be write-first: r_line = old word merged with the enabled new bytes.
REQ-022 exc update at each accepted edge: if write, exc <= write out of range; else if read, exc <= read out of range; else exc holds.
REQ-023 Reads and writes at busy-high edges SHALL be ignored: no memory change, r_valid stays 0, exc holds.
REQ-024 FSM states IDLE and INIT; busy SHALL equal (state == INIT).
REQ-025 INIT: each cycle SHALL write 0 to mem[cnt] and increment cnt from 0; after the write to DEPTH-1, it SHALL enter IDLE, so busy is high exactly DEPTH cycles after rst_n rises.
REQ-026 IDLE SHALL be terminal until the next reset.

Reset
REQ-027 rst_n low SHALL immediately force r_line = 0, r_valid = 0, exc = 0, cnt = 0.
REQ-028 State after reset SHALL be INIT if the init feature is compiled in, else IDLE (busy = 0).
REQ-029 Reset asserted mid-INIT SHALL restart the sweep from index 0; memory contents are not otherwise reset.

Configuration
REQ-030 Macro EMB_RAM_PARAM_INIT_EN defined: INIT sweep per REQ-025; after busy falls, every word SHALL read 0.
REQ-031 Macro EMB_RAM_PARAM_INIT_EN undefined: no INIT state or counter, busy tied 0, memory contents undefined until written.

Verification
REQ-032 INIT_EN, DEPTH=1024: release rst_n -> busy high exactly 1024 cycles; then read 0x3FF -> r_line=0x00000000, r_valid=1, exc=0.
REQ-033 Write 0x12345678 to 0x010 with w_be=0xF, then w_line=0xAABBCCDD with w_be=0x5 -> read 0x010 returns 0x12BB56DD one cycle later.
REQ-034 Same edge: read and write 0x020 (old 0x0, w_line=0xFFFFFFFF, w_be=0xC) -> r_line=0xFFFF0000.
REQ-035 Read 0x400 -> r_valid=1, r_line=0, exc=1; idle cycle -> exc stays 1; write 0x5 in range -> exc=0.
REQ-036 Simultaneous write to 0x800 and in-range read -> exc=1 (write wins), memory unchanged, read data correct.
REQ-037 Assert rst_n low at INIT cycle 500, release -> busy high a further full 1024 cycles; requests during busy produce no r_valid.
